// File: rtl/cpx_vec_pack.sv
// cpx_vec_pack: packs a serial complex I/Q stream into length-element vectors.
// Build option: define CPX_VEC_PACK_SLIDE_EN for a stride-1 sliding window.
module cpx_vec_pack #(
    parameter int i_bits   = 12,
    parameter int q_bits   = 12,
    parameter int length   = 5,
    parameter int cnt_bits = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_axis_sample_tvalid,
    output logic                       s_axis_sample_tready,
    input  logic [i_bits-1:0]          sample_i,
    input  logic [q_bits-1:0]          sample_q,
    input  logic                       flush,
    output logic                       s_axis_vec_tvalid,
    input  logic                       m_axis_vec_tready,
    output logic [i_bits*length-1:0]   xi,
    output logic [q_bits*length-1:0]   xq
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    localparam logic [cnt_bits-1:0] LEN = cnt_bits'(length);

    state_t               state, state_nx;
    logic [cnt_bits-1:0]  count, count_nx, cnt_inc;
    logic                 vld, vld_nx;
    logic                 accept, vec_hs;
    logic [i_bits*length-1:0] xi_r;
    logic [q_bits*length-1:0] xq_r;

    assign s_axis_sample_tready = (state == FILL) && rst_n;
    assign accept = m_axis_sample_tvalid && s_axis_sample_tready && !flush;
    assign vec_hs = vld && m_axis_vec_tready;

    // A full window (slide mode) stays full as samples shift through.
    assign cnt_inc = (count == LEN) ? LEN : count + cnt_bits'(1);

    always_comb begin
        state_nx = state;
        count_nx = count;
        vld_nx   = vld;
        if (flush) begin
            state_nx = FILL;
            count_nx = '0;
            vld_nx   = 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        count_nx = cnt_inc;
                        if (cnt_inc == LEN) begin
                            state_nx = HOLD;
                            vld_nx   = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (vec_hs) begin
                        state_nx = FILL;
                        vld_nx   = 1'b0;
`ifdef CPX_VEC_PACK_SLIDE_EN
                        count_nx = LEN;
`else
                        count_nx = '0;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            count <= '0;
            vld   <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            vld   <= vld_nx;
        end
    end

    // Newest sample enters the top element; element 0 is the oldest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xi_r <= '0;
            xq_r <= '0;
        end else if (accept) begin
            xi_r <= {sample_i, xi_r[i_bits*length-1:i_bits]};
            xq_r <= {sample_q, xq_r[q_bits*length-1:q_bits]};
        end
    end

    assign s_axis_vec_tvalid = vld;
    assign xi = xi_r;
    assign xq = xq_r;

endmodule

// File: doc/cpx_vec_pack.md
Name: cpx_vec_pack

Overview:
- Collects a serial stream of complex I/Q samples into packed length-element vectors.
- Presents each vector on xi/xq buses with a valid/ready handshake.
- Feeds the x or y operand port of the dot-product engine; it is the producer end of that vector interface.
- One instance per operand, upstream of the correlator datapath.

Parameters:
- i_bits, 12: width of each I sample and of each packed I element.
- q_bits, 12: width of each Q sample and of each packed Q element.
- length, 5: elements per vector; must be >= 2.
- cnt_bits, 8: width of the internal fill counter; must satisfy 2**cnt_bits > length.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_axis_sample_tvalid  input  1  input sample valid.
- s_axis_sample_tready  output  1  block can accept a sample this cycle.
- sample_i  input  i_bits  signed I sample.
- sample_q  input  q_bits  signed Q sample.
- flush  input  1  synchronous discard of the partial or held vector.
- s_axis_vec_tvalid  output  1  packed vector valid.
- m_axis_vec_tready  input  1  downstream accepts the vector.
- xi  output  i_bits*length  packed I vector; element k at bits [i_bits*k +: i_bits].
- xq  output  q_bits*length  packed Q vector; element k at bits [q_bits*k +: q_bits].

Behaviour:
- Clocking/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: s_axis_vec_tvalid=0, xi=0, xq=0, count=0, state=FILL.
- s_axis_sample_tready is combinational: 1 iff state==FILL and rst_n==1.
- Storage is a shift register. An accepted sample enters element length-1; element k takes element k+1. Element 0 is therefore the oldest sample.
- States: FILL, HOLD.
- FILL: accept when m_axis_sample_tvalid & s_axis_sample_tready; shift in the sample; count++.
  - When the accepted sample makes count==length: go to HOLD and set s_axis_vec_tvalid=1 on the same edge.
  - Latency: vector valid the cycle after the last sample is accepted.
- HOLD: s_axis_sample_tready=0; xi/xq and tvalid held stable regardless of upstream activity.
  - On s_axis_vec_tvalid & m_axis_vec_tready: tvalid<=0, count<=0, state<=FILL.
  - A new sample can be accepted the cycle after the handshake.
  - Throughput: length+1 cycles per vector.
- tvalid, once asserted, never drops without a handshake, except on flush or reset.
- flush has priority over all other events in the same cycle: count<=0, tvalid<=0, state<=FILL.
  - A sample presented in the flush cycle is not accepted, even though tready is 1 in FILL.
  - xi/xq are not cleared by flush.
- flush coincident with a vector handshake: the handshake still completes downstream, since tvalid&tready were both high. Internal state follows the flush rule.
- Reset mid-fill or mid-hold: immediate return to the reset values; the partial vector is lost.
- No arithmetic is performed. Samples are stored bit-exact with no sign extension or truncation.
- xi/xq keep their last contents between vectors and are meaningful only while tvalid=1.

Optional Feature:
- Macro: CPX_VEC_PACK_SLIDE_EN.
- Defined (sliding window, stride 1):
  - After a handshake in HOLD, count stays at length and state returns to FILL.
  - Each subsequent accepted sample shifts the window and sets tvalid=1 the next cycle.
  - Steady state: one new vector per 2 cycles.
  - flush clears count to 0, so a full refill of length samples is needed.
- Undefined (block mode, default): non-overlapping vectors as described in Behaviour.

Test Plan:
- Basic fill: reset; feed samples I=1..5, Q=-1..-5 with tvalid held high; ready held high -> tvalid rises 1 cycle after the 5th accept.
  - Expected xi elements [0..4] = 1,2,3,4,5; xq elements = -1..-5.
  - Sample tready low for exactly 1 cycle.
- Backpressure: complete a fill with m_axis_vec_tready=0 for 10 cycles -> xi/xq/tvalid stable and sample tready=0 throughout.
  - Raise ready -> handshake occurs; tready returns to 1 the next cycle.
- Flush mid-fill: accept 3 samples, pulse flush with a valid sample present -> that sample is not accepted.
  - The next 5 samples (10..14) produce xi = 10..14.
- Flush in HOLD: full vector held, assert flush and vec_tready together -> one handshake, then tvalid=0 and count=0.
- Async reset mid-fill: deassert rst_n between clock edges after 2 accepts -> tvalid=0 and xi=0 immediately, with no clock edge required.
  - After release, 5 new samples yield a clean vector.
- Slide (CPX_VEC_PACK_SLIDE_EN): feed 1..7 with ready held high -> vectors {1..5}, {2..6}, {3..7}.
  - After the first vector, a new vector every 2 cycles.
